// File: rtl/mod4051_chunk_accumulator_if.sv
// Handshake bundle between the per-chunk residue LUT bank, the accumulator and the residue consumer.
`timescale 1ns/1ps
interface mod4051_chunk_accumulator_if #(parameter int W = 12);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/mod4051_chunk_accumulator.sv
// Serial modular accumulator: sums N_TERMS chunk residues mod MOD through one shared adder/reducer.
`timescale 1ns/1ps
module mod4051_chunk_accumulator #(
  parameter int MOD     = 4051,
  parameter int W       = 12,
  parameter int N_TERMS = 67
) (
  input logic clk,
  input logic rst,
  mod4051_chunk_accumulator_if.slave bus
);

  typedef enum logic {ACC, DONE} state_t;

  localparam logic [W:0] MOD1 = (W+1)'(MOD);
  localparam logic [W:0] MOD2 = (W+1)'(2*MOD);
  localparam logic [7:0] LAST = 8'(N_TERMS-1);

  state_t       state, state_nxt;
  logic [W-1:0] acc, acc_nxt;
  logic [W-1:0] out_q, out_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic         busy_q, busy_nxt;
  logic [W:0]   s;
  logic [W-1:0] r;
  logic         accept;

  // acc < MOD and in_data < 2*MOD, so two conditional subtractions always land below MOD
  always_comb begin
    s = {1'b0, acc} + {1'b0, bus.in_data};
    if (s >= MOD2)      r = W'(s - MOD2);
    else if (s >= MOD1) r = W'(s - MOD1);
    else                r = W'(s);
  end

  assign accept = bus.in_valid && (state == ACC);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    busy_nxt  = busy_q;
    case (state)
      ACC: if (accept) begin
        busy_nxt = 1'b1;
        if (cnt == LAST) begin
          out_nxt   = r;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          acc_nxt = r;
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: if (bus.out_ready) begin
        busy_nxt  = 1'b0;
        state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACC;
      acc    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Handshake flags are pure decodes of the state register
  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mod4051_chunk_accumulator.sv
// Bench for mod4051_chunk_accumulator: operand-level sum-mod model checked every cycle, plus literal results.
`timescale 1ns/1ps
module tb_mod4051_chunk_accumulator;
  localparam int MOD = 4051;
  localparam int NT [2] = '{67, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv [2];
  logic        ordy [2];
  logic [11:0] id [2];
  logic        irdy [2];
  logic        ovld [2];
  logic        bsy [2];
  logic [11:0] od [2];

  mod4051_chunk_accumulator_if #(.W(12)) b0 ();
  mod4051_chunk_accumulator_if #(.W(12)) b1 ();

  assign b0.in_valid  = iv[0];
  assign b0.in_data   = id[0];
  assign b0.out_ready = ordy[0];
  assign irdy[0]      = b0.in_ready;
  assign ovld[0]      = b0.out_valid;
  assign od[0]        = b0.out_data;
  assign bsy[0]       = b0.busy;
  assign b1.in_valid  = iv[1];
  assign b1.in_data   = id[1];
  assign b1.out_ready = ordy[1];
  assign irdy[1]      = b1.in_ready;
  assign ovld[1]      = b1.out_valid;
  assign od[1]        = b1.out_data;
  assign bsy[1]       = b1.busy;

  mod4051_chunk_accumulator #(.MOD(4051), .W(12), .N_TERMS(67)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mod4051_chunk_accumulator #(.MOD(4051), .W(12), .N_TERMS(3))  dut1 (.clk(clk), .rst(rst), .bus(b1));

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(input int d, input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, d, $time, act, exp);
    end
  endfunction

  // Operand model: running integer sum of accepted terms, reduced once when the operand is complete
  int  msum [2]  = '{0, 0};
  int  mcnt [2]  = '{0, 0};
  bit  mpend [2] = '{0, 0};
  int  mval [2]  = '{0, 0};
  int  mlast [2] = '{0, 0};
  int  nout [2]  = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk(d, "out_valid", int'(ovld[d]), int'(mpend[d]));
      chk(d, "in_ready",  int'(irdy[d]), int'(!mpend[d]));
      chk(d, "busy",      int'(bsy[d]),  int'((mcnt[d] > 0) || mpend[d]));
      chk(d, "out_data",  int'(od[d]),   mpend[d] ? mval[d] : mlast[d]);
      if (mpend[d]) chk(d, "out_lt_mod", int'(int'(od[d]) < MOD), 1);
      if (rst) begin
        msum[d] = 0; mcnt[d] = 0; mpend[d] = 0; mlast[d] = 0;
      end else if (!mpend[d] && iv[d]) begin
        msum[d] += int'(id[d]);
        mcnt[d]++;
        if (mcnt[d] == NT[d]) begin
          mpend[d] = 1; mval[d] = msum[d] % MOD; msum[d] = 0; mcnt[d] = 0;
        end
      end else if (mpend[d] && ordy[d]) begin
        mpend[d] = 0; mlast[d] = mval[d]; nout[d]++;
      end
    end
  end

  int terms[$];

  task automatic fill(input int n, input int v);
    terms.delete();
    for (int i = 0; i < n; i++) terms.push_back(v);
  endtask

  task automatic feed(input int d, input int duty);
    int i = 0;
    int g = 0;
    while (i < terms.size() && g < 20000) begin
      iv[d] = ($urandom_range(99) < duty);
      id[d] = 12'(terms[i]);
      if (iv[d] && irdy[d]) i++;
      @(posedge clk); #1;
      g++;
    end
    iv[d] = 1'b0;
    if (i < terms.size()) begin
      nvec++; nerr++;
      $display("FAIL feed_timeout dut%0d: got %0d terms accepted expected %0d", d, i, terms.size());
    end
  endtask

  task automatic wait_out(input int d, input int exp, input string nm);
    int g = 0;
    while (!(ovld[d] && ordy[d]) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) begin
      nvec++; nerr++;
      $display("FAIL %s dut%0d: got no output handshake expected %0d", nm, d, exp);
    end else begin
      chk(d, nm, int'(od[d]), exp);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n0;
    bit fdone;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fill(67, 1008); feed(0, 100); wait_out(0, 2720, "op_1008");

    // Unreduced inputs held behind a stalled consumer, with ignored in_valid pulses
    ordy[0] = 1'b0;
    fill(67, 4095); feed(0, 100);
    for (int i = 0; i < 10; i++) begin
      iv[0] = i[0]; id[0] = 12'($urandom);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    wait_out(0, 2948, "op_4095_stall");
    fill(67, 0); feed(0, 100); wait_out(0, 0, "op_zeros");

    fill(3, 4050); feed(1, 100); wait_out(1, 4048, "n3_2mod_path");

    terms.delete();
    for (int k = 0; k < 67; k++) terms.push_back(k);
    feed(0, 30); wait_out(0, 2211, "op_bubbly_k");

    fill(20, 1008); feed(0, 100);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    fill(67, 1008); feed(0, 100); wait_out(0, 2720, "op_after_rst");

    ordy[0] = 1'b0;
    fill(67, 1); feed(0, 100);
    chk(0, "done_before_rst", int'(ovld[0]), 1);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    chk(0, "rst_in_done", int'(ovld[0]), 0);
    ordy[0] = 1'b1;

    // Random regression on the 3-term instance, then a few full-length operands
    terms.delete();
    for (int i = 0; i < 3000; i++) terms.push_back(int'($urandom_range(4095)));
    n0 = nout[1]; fdone = 0;
    fork
      begin feed(1, 50); fdone = 1; end
      begin
        while (!fdone) begin ordy[1] = 1'($urandom_range(1)); @(posedge clk); #1; end
        ordy[1] = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk(1, "regr_operands", nout[1] - n0, 1000);

    terms.delete();
    for (int i = 0; i < 67 * 12; i++) terms.push_back(int'($urandom_range(4095)));
    n0 = nout[0]; fdone = 0;
    fork
      begin feed(0, 60); fdone = 1; end
      begin
        while (!fdone) begin ordy[0] = 1'($urandom_range(1)); @(posedge clk); #1; end
        ordy[0] = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk(0, "regr67_operands", nout[0] - n0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
